// File: rtl/coherence_bus_ctrl.sv
// Dual-core memory/coherence controller: arbitrates two dcaches and two icaches
// onto one RAM port and runs dcache-to-dcache snoops (invalidate, dirty supply).
module coherence_bus_ctrl #(
    parameter int CPUS  = 2,
    parameter int ADDRW = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [CPUS-1:0]            iREN,
    input  logic [CPUS-1:0][ADDRW-1:0] iaddr,
    output logic [CPUS-1:0]            iwait,
    output logic [CPUS-1:0][ADDRW-1:0] iload,
    input  logic [CPUS-1:0]            dREN,
    input  logic [CPUS-1:0]            dWEN,
    input  logic [CPUS-1:0][ADDRW-1:0] daddr,
    input  logic [CPUS-1:0][ADDRW-1:0] dstore,
    output logic [CPUS-1:0]            dwait,
    output logic [CPUS-1:0][ADDRW-1:0] dload,
    input  logic [CPUS-1:0]            cctrans,
    input  logic [CPUS-1:0]            ccwrite,
    output logic [CPUS-1:0]            ccwait,
    output logic [CPUS-1:0]            ccinv,
    output logic [CPUS-1:0][ADDRW-1:0] ccsnoopaddr,
    output logic [ADDRW-1:0]           ramaddr,
    output logic [ADDRW-1:0]           ramstore,
    output logic                       ramREN,
    output logic                       ramWEN,
    input  logic [ADDRW-1:0]           ramload,
    input  logic [1:0]                 ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, SNOOP, C2C0, C2C1, LD0, LD1, IFETCH
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   req_q, req_d;
    logic   upg_q, upg_d;

    logic            snp;
    logic [CPUS-1:0] d_req;
    logic [CPUS-1:0] cand;
    logic            grant_core;

    // Any dcache request outranks every icache request; ties go to the core not served last.
    assign snp        = ~req_q;
    assign d_req      = (dWEN & ~cctrans) | (cctrans & (dREN | ccwrite));
    assign cand       = (d_req != '0) ? d_req : iREN;
    assign grant_core = (&cand) ? ~last_grant_q : cand[1];

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            req_q        <= 1'b0;
            upg_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            upg_q        <= upg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        upg_d        = upg_q;
        iwait        = '1;
        dwait        = '1;
        iload        = '0;
        dload        = '0;
        ccwait       = '0;
        ccinv        = '0;
        ccsnoopaddr  = '0;
        ramaddr      = '0;
        ramstore     = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    last_grant_d = grant_core;
                    req_d        = grant_core;
                    upg_d        = 1'b0;
                    if (d_req != '0) begin
                        if (dWEN[grant_core] && !cctrans[grant_core]) begin
                            state_d = WB0;
                        end else begin
                            state_d = SNOOP;
                            upg_d   = !dREN[grant_core];
                        end
                    end else begin
                        state_d = IFETCH;
                    end
                end
            end
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[req_q];
                ramstore = dstore[req_q];
                if (ramstate == RAM_ACCESS) begin
                    dwait[req_q] = 1'b0;
                    state_d      = (state_q == WB0) ? WB1 : IDLE;
                end
            end
            SNOOP: begin
                ccwait[snp]      = 1'b1;
                ccsnoopaddr[snp] = daddr[req_q];
                ccinv[snp]       = ccwrite[req_q];
                if (cctrans[snp]) begin
                    if (upg_q) begin
                        dwait[req_q] = 1'b0;
                        state_d      = IDLE;
                    end else if (ccwrite[snp]) begin
                        state_d = C2C0;
                    end else begin
                        state_d = LD0;
                    end
                end
            end
            // Dirty supplier feeds the requester and RAM in the same beat so memory stays coherent.
            C2C0, C2C1: begin
                ccwait[snp]  = 1'b1;
                ramWEN       = 1'b1;
                ramaddr      = daddr[snp];
                ramstore     = dstore[snp];
                dload[req_q] = dstore[snp];
                if (ramstate == RAM_ACCESS) begin
                    dwait[req_q] = 1'b0;
                    dwait[snp]   = 1'b0;
                    state_d      = (state_q == C2C0) ? C2C1 : IDLE;
                end
            end
            LD0, LD1: begin
                ramREN       = 1'b1;
                ramaddr      = daddr[req_q];
                dload[req_q] = ramload;
                if (ramstate == RAM_ACCESS) begin
                    dwait[req_q] = 1'b0;
                    state_d      = (state_q == LD0) ? LD1 : IDLE;
                end
            end
            IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[req_q];
                iload[req_q] = ramload;
                if (ramstate == RAM_ACCESS) begin
                    iwait[req_q] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Testbench for coherence_bus_ctrl: plays both caches and the RAM, predicting
// every cycle from a transaction-level model of the controller's rules.
`timescale 1ns/1ps
module tb_coherence_bus_ctrl;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam int M_WB = 0, M_LD = 1, M_C2C = 2, M_IF = 3;

    typedef enum int {K_NONE, K_WB, K_FILL, K_UPG, K_IF} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] base;
        bit          excl;
    } req_t;

    typedef struct {
        logic [1:0] dmask;
        logic [1:0] imask;
        int         exp_core;
    } vec_t;

    logic             CLK, nRST;
    logic [1:0]       iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
    logic [1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic             ramREN, ramWEN;
    logic [1:0]       ramstate;

    int checks = 0;
    int errors = 0;
    int model_last = 1;
    bit hold_random = 1'b0;

    coherence_bus_ctrl #(.CPUS(2), .ADDRW(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkOutput(name, {32'd0, actual}, {32'd0, expected});
    endtask

    task automatic checkCycle(input string tag, input logic [1:0] e_iw, e_dw, e_ccw, e_inv,
                              input logic e_ren, e_wen, input logic [31:0] e_addr);
        checkOutput({tag, " waits"}, {56'd0, iwait, dwait, ccwait, ccinv}, {56'd0, e_iw, e_dw, e_ccw, e_inv});
        checkOutput({tag, " ram"}, {30'd0, ramREN, ramWEN, ramaddr}, {30'd0, e_ren, e_wen, e_addr});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        cctrans = '0; ccwrite = '0; ramload = '0; ramstate = FREE;
    endtask

    function automatic logic [1:0] hold_state();
        if (!hold_random) return BUSY;
        case ($urandom_range(0, 2))
            0:       return FREE;
            1:       return BUSY;
            default: return ERROR;
        endcase
    endfunction

    // Winner: dcache class first, single requester wins, a tie goes to the core not served last.
    function automatic int model_arbitrate(input req_t r0, input req_t r1, output bit any);
        logic [1:0] dm, im, m;
        int w;
        dm = {r1.kind inside {K_WB, K_FILL, K_UPG}, r0.kind inside {K_WB, K_FILL, K_UPG}};
        im = {r1.kind == K_IF, r0.kind == K_IF};
        m = (dm != 2'b00) ? dm : im;
        any = (m != 2'b00);
        w = (m == 2'b11) ? 1 - model_last : (m[1] ? 1 : 0);
        if (any) model_last = w;
        return w;
    endfunction

    task automatic drive_req(input int c, input req_t r);
        case (r.kind)
            K_WB:   begin dWEN[c] = 1'b1; daddr[c] = r.base; end
            K_FILL: begin dREN[c] = 1'b1; cctrans[c] = 1'b1; ccwrite[c] = r.excl; daddr[c] = r.base; end
            K_UPG:  begin cctrans[c] = 1'b1; ccwrite[c] = 1'b1; daddr[c] = r.base; end
            K_IF:   begin iREN[c] = 1'b1; iaddr[c] = r.base; end
            default: ;
        endcase
    endtask

    task automatic runBlock(input int mode, input int win, input req_t r,
                            input logic [31:0] w0, input logic [31:0] w1, input int busy);
        int          snp;
        int          nw;
        bit          acc;
        logic [31:0] words [2];
        logic [31:0] addr;
        logic [1:0]  e_iw, e_dw, e_ccw;
        string       tag;
        snp = 1 - win;
        nw = (mode == M_IF) ? 1 : 2;
        words[0] = w0;
        words[1] = w1;
        tag = (mode == M_WB) ? "wb" : (mode == M_LD) ? "ld" : (mode == M_C2C) ? "c2c" : "if";
        for (int w = 0; w < nw; w++) begin
            addr = r.base + 32'(4 * w);
            for (int b = 0; b <= busy; b++) begin
                acc = (b == busy);
                step();
                clear_inputs();
                drive_req(win, r);
                case (mode)
                    M_WB:  begin daddr[win] = addr; dstore[win] = words[w]; end
                    M_LD:  begin daddr[win] = addr; ramload = acc ? words[w] : $urandom(); end
                    M_C2C: begin
                        daddr[win] = r.base; dWEN[snp] = 1'b1;
                        daddr[snp] = addr; dstore[snp] = words[w];
                    end
                    default: ramload = acc ? words[0] : $urandom();
                endcase
                ramstate = acc ? ACCESS : hold_state();
                #2;
                e_iw = 2'b11; e_dw = 2'b11; e_ccw = 2'b00;
                if (mode == M_C2C) e_ccw[snp] = 1'b1;
                if (acc) begin
                    if (mode == M_IF) e_iw[win] = 1'b0;
                    else e_dw[win] = 1'b0;
                    if (mode == M_C2C) e_dw[snp] = 1'b0;
                end
                checkCycle(tag, e_iw, e_dw, e_ccw, 2'b00,
                           mode inside {M_LD, M_IF}, mode inside {M_WB, M_C2C}, addr);
                if (mode inside {M_WB, M_C2C}) checkWord({tag, " ramstore"}, ramstore, words[w]);
                if (acc && mode inside {M_LD, M_C2C}) checkWord({tag, " dload"}, dload[win], words[w]);
                if (acc && mode == M_IF) checkWord("if iload", iload[win], words[0]);
            end
        end
    endtask

    task automatic runSnoop(input int win, input req_t r, input bit dirty, input int delay);
        int         snp;
        bit         reply;
        logic [1:0] e_dw, e_ccw, e_inv;
        snp = 1 - win;
        for (int d = 0; d <= delay; d++) begin
            reply = (d == delay);
            step();
            clear_inputs();
            drive_req(win, r);
            cctrans[snp] = reply;
            ccwrite[snp] = reply & dirty;
            ramstate = hold_state();
            #2;
            e_dw = 2'b11;
            if (reply && r.kind == K_UPG) e_dw[win] = 1'b0;
            e_ccw = 2'b00; e_ccw[snp] = 1'b1;
            e_inv = 2'b00; e_inv[snp] = (r.kind == K_UPG) ? 1'b1 : r.excl;
            checkCycle("snoop", 2'b11, e_dw, e_ccw, e_inv, 1'b0, 1'b0, 32'd0);
            checkWord("snoop addr", ccsnoopaddr[snp], r.base);
            checkWord("owner snoop addr", ccsnoopaddr[win], 32'd0);
        end
    endtask

    // One arbitration cycle plus the winner's whole transaction; forced_win >= 0 pins the expected winner.
    task automatic applyStimulus(input req_t r0, input req_t r1, input bit dirty,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input int busy, input int delay, input int forced_win);
        int   win;
        bit   any;
        req_t r;
        if (forced_win >= 0) begin
            win = forced_win;
            any = 1'b1;
            model_last = win;
        end else begin
            win = model_arbitrate(r0, r1, any);
        end
        step();
        clear_inputs();
        drive_req(0, r0);
        drive_req(1, r1);
        ramstate = hold_state();
        #2;
        checkCycle("grant", 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
        if (!any) return;
        r = (win == 0) ? r0 : r1;
        case (r.kind)
            K_WB:   runBlock(M_WB, win, r, w0, w1, busy);
            K_IF:   runBlock(M_IF, win, r, w0, w1, busy);
            K_UPG:  runSnoop(win, r, dirty, delay);
            K_FILL: begin
                runSnoop(win, r, dirty, delay);
                runBlock(dirty ? M_C2C : M_LD, win, r, w0, w1, busy);
            end
            default: ;
        endcase
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.kind = kind_t'($urandom_range(0, 4));
        r.base = $urandom() & 32'hFFFF_FFF8;
        r.excl = 1'($urandom_range(0, 1));
        return r;
    endfunction

    initial begin
        vec_t vecs [11];
        req_t a, b, none;
        none = '{kind: K_NONE, base: 32'd0, excl: 1'b0};
        vecs = '{'{2'b11, 2'b00, 0}, '{2'b11, 2'b00, 1}, '{2'b01, 2'b10, 0},
                 '{2'b00, 2'b11, 1}, '{2'b00, 2'b11, 0}, '{2'b10, 2'b01, 1},
                 '{2'b00, 2'b10, 1}, '{2'b11, 2'b00, 0}, '{2'b01, 2'b00, 0},
                 '{2'b10, 2'b00, 1}, '{2'b11, 2'b00, 0}};

        nRST = 1'b1;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #3;
        checkCycle("reset", 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
        checkWord("reset ramstore", ramstore, 32'd0);
        checkOutput("reset dload", dload, 64'd0);
        checkOutput("reset iload", iload, 64'd0);
        checkOutput("reset snoopaddr", ccsnoopaddr, 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        model_last = 1;

        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (c == 0) a = none; else b = none;
                if (vecs[i].dmask[c]) begin
                    if (c == 0) a = '{K_WB, 32'h1000, 1'b0}; else b = '{K_WB, 32'h1100, 1'b0};
                end else if (vecs[i].imask[c]) begin
                    if (c == 0) a = '{K_IF, 32'h2000, 1'b0}; else b = '{K_IF, 32'h2100, 1'b0};
                end
            end
            applyStimulus(a, b, 1'b0, $urandom(), $urandom(), 1, 0, vecs[i].exp_core);
        end

        applyStimulus('{K_FILL, 32'h40, 1'b0}, none, 1'b0, 32'hAAAA0000, 32'hAAAA0004, 2, 0, -1);
        applyStimulus('{K_FILL, 32'h200, 1'b0}, '{K_IF, 32'h100, 1'b0}, 1'b0, 32'h11, 32'h22, 1, 1, -1);
        applyStimulus(none, '{K_IF, 32'h100, 1'b0}, 1'b0, 32'h0BAD_F00D, 32'h0, 1, 0, -1);
        applyStimulus('{K_FILL, 32'h80, 1'b1}, none, 1'b1, 32'hDEADBEEF, 32'h12345678, 1, 1, -1);
        applyStimulus('{K_UPG, 32'hC0, 1'b1}, none, 1'b0, 32'h0, 32'h0, 0, 0, -1);

        hold_random = 1'b1;
        for (int n = 0; n < 80; n++) begin
            a = rand_req();
            b = rand_req();
            applyStimulus(a, b, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
        end

        hold_random = 1'b0;
        a = '{K_FILL, 32'h300, 1'b0};
        model_last = 0;
        step(); clear_inputs(); drive_req(0, a); #2;
        checkCycle("rst grant", 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
        step(); clear_inputs(); drive_req(0, a); cctrans[1] = 1'b1; #2;
        checkCycle("rst snoop", 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'd0);
        step(); clear_inputs(); drive_req(0, a); ramstate = ACCESS; ramload = 32'h5; #2;
        checkCycle("rst ld0", 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 32'h300);
        step(); clear_inputs(); drive_req(0, a); daddr[0] = 32'h304; ramstate = BUSY; #2;
        checkCycle("rst ld1", 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h304);
        nRST = 1'b1;
        #1;
        checkCycle("async reset", 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
        step();
        step();
        clear_inputs();
        nRST = 1'b0;
        model_last = 1;
        applyStimulus('{K_WB, 32'h500, 1'b0}, '{K_WB, 32'h600, 1'b0}, 1'b0, 32'h77, 32'h88, 1, 0, -1);
        applyStimulus('{K_FILL, 32'h700, 1'b0}, none, 1'b0, 32'h99, 32'hAA, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Dual-core memory/coherence controller sitting directly downstream of both cores' dcache and icache, on the cache_control side.
- Arbitrates four cache ports onto the single RAM port.
- Runs snoop transactions between the two dcaches (invalidate, dirty cache-to-cache supply).
- Returns dload/iload and wait signals to the caches. Blocks are two words (word0 at addr[2]=0, word1 at addr[2]=1).

Parameters:
CPUS, 2, number of cores; fixed at 2, indexes every per-core vector below
ADDRW, 32, address/data word width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous reset, active-high (1 = reset), despite the name
iREN  in  2  icache read request per core
iaddr  in  2x32  icache word address
iwait  out  2  icache wait; 0 for exactly one cycle when iload is valid
iload  out  2x32  icache read data
dREN  in  2  dcache read request (miss fill)
dWEN  in  2  dcache write request (writeback, or snoop data supply)
daddr  in  2x32  dcache word address
dstore  in  2x32  dcache write data
dwait  out  2  dcache wait; 0 for one cycle per completed word
dload  out  2x32  dcache read data
cctrans  in  2  coherence transaction / snoop reply valid
ccwrite  in  2  with request: exclusive intent; with snoop reply: dirty copy held
ccwait  out  2  core is being snooped; its dcache must stall its datapath
ccinv  out  2  invalidate snooped block
ccsnoopaddr  out  2x32  address of snooped block
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
Reset:
- State IDLE, last_grant=1 (core0 wins first tie).
- All wait outputs = 1; ccwait, ccinv, ramREN, ramWEN = 0; data and address outputs = 0.
- Reset mid-transaction aborts immediately; no partial state survives.

Arbitration (IDLE only):
- dcache requests beat icache requests.
- Within a class, a single requester wins. Simultaneous requesters from both cores: the core != last_grant wins.
- last_grant updates on every grant.
- Owner (req) and other core (snp) are registered at grant.

States:
- IDLE -> WB0 on dWEN without cctrans (writeback). WB0/WB1: ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req]. dwait[req]=0 in the ramstate==ACCESS cycle; each ACCESS advances WB0->WB1->IDLE.
- IDLE -> SNOOP on dREN&cctrans (fill), or on cctrans&ccwrite without dREN (upgrade).
- SNOOP: ccwait[snp]=1, ccsnoopaddr[snp]=daddr[req], ccinv[snp]=ccwrite[req]. Stay until cctrans[snp]=1.
  - Upgrade request: on the reply -> IDLE, with dwait[req]=0 for one cycle.
  - Reply with ccwrite[snp]=1 -> C2C0.
  - Otherwise -> LD0.
- C2C0/C2C1: ccwait[snp] held. ramWEN=1, ramaddr=daddr[snp], ramstore=dstore[snp]. dload[req]=dstore[snp].
  - On ACCESS: dwait[req]=0 and dwait[snp]=0 together. Advance to C2C1, then IDLE.
  - The snooped line is written back so RAM stays coherent.
- LD0/LD1: ramREN=1, ramaddr=daddr[req], dload[req]=ramload. dwait[req]=0 on ACCESS. Advance to LD1, then IDLE.
- IDLE -> IF on an icache grant. IF: ramREN=1, ramaddr=iaddr[req], iload[req]=ramload. iwait[req]=0 on ACCESS, then IDLE.

Rules:
- BUSY, FREE and ERROR in a RAM state hold the state, with waits at 1 and the request held.
- Exactly one of ramREN/ramWEN is asserted at a time; both are 0 in IDLE and SNOOP.
- A requester that drops its request mid-block is not supported; the FSM completes the block.
- Non-owner waits stay at 1, except dwait[snp] in C2C.
- Outputs are combinational from registered state plus inputs. State and grant are registered.

Test Plan:
1. Reset then nRST=0; core0 dREN=1, cctrans=1, ccwrite=0, daddr=0x40; snoop reply cctrans[1]=1, ccwrite[1]=0; RAM ACCESS after 2 BUSY cycles, returning 0xAAAA0000 then 0xAAAA0004 -> dload[0] matches; dwait[0] low exactly 2 cycles; ccwait[1] high only in SNOOP.
2. Core0 dREN and core1 iREN in the same cycle -> dcache served first. Then iload[1] = ramload for iaddr 0x100, with iwait[1] low 1 cycle.
3. Both cores dREN in the same cycle after reset -> core0 granted; the next simultaneous pair -> core1 granted.
4. Core1 has a dirty line: core0 read-exclusive at 0x80 (ccwrite=1); reply ccwrite[1]=1 with dstore[1]=0xDEADBEEF/0x12345678 -> ccinv[1]=1; RAM written at 0x80/0x84; dload[0] equals those words.
5. Core0 upgrade (cctrans=1, ccwrite=1, no dREN) -> ccinv[1]=1 for one snoop; no RAM access; dwait[0] low 1 cycle.
6. Assert nRST during LD1 -> waits forced to 1 and ram strobes to 0 asynchronously; after release, state is IDLE and a new request is served normally.
